ram_bus_arbiter: RTL

//   Two-master round-robin arbiter and sequencer for the shared 8-bit data bus and single-port RAM.
//   M0 is the CPU-side master and M1 is a DMA/peripheral master; each issues single-byte transactions.
//   The block drives BUS_ADDR/BUS_WE/BUS_DATA on the winner's behalf.
//   It also absorbs the RAM's registered read latency, so a master sees a simple REQ/ACK interface.

---
 rtl/ram_bus_arbiter_if.sv | 32 +++
 rtl/ram_bus_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter_if.sv
// Bundle of master request/acknowledge signals and shared-bus control for ram_bus_arbiter.
//   slave  modport: the arbiter side (samples requests, drives ACKs, RDATA, BUSY and bus control)
//   master modport: the requester/test side (drives requests, observes everything else)
// BUS_DATA is a true tri-state net and is carried as a separate inout port on the arbiter.
interface ram_bus_arbiter_if;
  logic       m0_req;
  logic [7:0] m0_addr;
  logic       m0_we;
  logic [7:0] m0_wdata;
  logic       m0_ack;
  logic       m1_req;
  logic [7:0] m1_addr;
  logic       m1_we;
  logic [7:0] m1_wdata;
  logic       m1_ack;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] bus_addr;
  logic       bus_we;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m0_ack, m1_ack, rdata, busy, bus_addr, bus_we
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m0_ack, m1_ack, rdata, busy, bus_addr, bus_we
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for a shared 8-bit bus and single-port RAM.
// M0 (CPU side) and M1 (DMA/peripheral) each issue single-byte transactions over a level REQ /
// one-cycle ACK handshake. The winner's address, write enable and write data are latched at the
// grant edge and replayed onto the shared bus; the RAM's registered read latency is absorbed by
// a WAIT phase so RDATA is valid in the ACK cycle of a read.
//
// Ports
//   CLK       system clock, rising edge
//   RESET     asynchronous, active-low reset
//   bus       ram_bus_arbiter_if.slave: M0/M1 REQ/ADDR/WE/WDATA in, M0/M1 ACK, RDATA, BUSY,
//             BUS_ADDR, BUS_WE out
//   BUS_DATA  shared data bus; driven only during a write address cycle, otherwise high-Z
//
// Parameters
//   PARK_ADDR  BUS_ADDR value whenever no transaction occupies the bus
//   RD_WAIT    cycles from the read address cycle to read-data capture, 1..7
module ram_bus_arbiter #(
  parameter logic [7:0]  PARK_ADDR = 8'hFF,
  parameter int unsigned RD_WAIT   = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  ram_bus_arbiter_if.slave bus,
  inout  wire  [7:0]       BUS_DATA
);

  // The WAIT counter starts at RD_WAIT-1 and captures when it reaches zero.
  localparam logic [2:0] WaitLoad = 3'(RD_WAIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWait,
    StDone
  } state_e;

  state_e     state_q;
  logic       ptr_q;       // 1: M1 wins a tie, 0: M0 wins a tie
  logic       gnt_q;       // master currently being served (0 = M0, 1 = M1)
  logic       we_q;
  logic [7:0] wdata_q;
  logic [2:0] cnt_q;
  logic [7:0] bus_addr_q;
  logic       bus_we_q;
  logic       drive_q;     // BUS_DATA output enable
  logic       busy_q;
  logic       m0_ack_q;
  logic       m1_ack_q;
  logic [7:0] rdata_q;

  // A lone requester always wins; the pointer only settles a tie.
  logic pick_m1;
  assign pick_m1 = bus.m1_req & (~bus.m0_req | ptr_q);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      cnt_q      <= 3'd0;
      bus_addr_q <= PARK_ADDR;
      bus_we_q   <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      // ACKs are single-cycle pulses raised only on entry to StDone.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.m0_req || bus.m1_req) begin
            gnt_q      <= pick_m1;
            we_q       <= pick_m1 ? bus.m1_we    : bus.m0_we;
            wdata_q    <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
            bus_addr_q <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
            bus_we_q   <= pick_m1 ? bus.m1_we    : bus.m0_we;
            drive_q    <= pick_m1 ? bus.m1_we    : bus.m0_we;
            busy_q     <= 1'b1;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          // The RAM commits a write at the edge that ends this cycle.
          bus_we_q <= 1'b0;
          drive_q  <= 1'b0;
          if (we_q) begin
            bus_addr_q <= PARK_ADDR;
            m0_ack_q   <= ~gnt_q;
            m1_ack_q   <= gnt_q;
            state_q    <= StDone;
          end else begin
            cnt_q   <= WaitLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          // Address is held so the RAM's registered output stays valid until capture.
          if (cnt_q == 3'd0) begin
            rdata_q    <= BUS_DATA;
            bus_addr_q <= PARK_ADDR;
            m0_ack_q   <= ~gnt_q;
            m1_ack_q   <= gnt_q;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StDone: begin
          ptr_q   <= ~gnt_q;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign BUS_DATA     = drive_q ? wdata_q : 8'hzz;
  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_we   = bus_we_q;
  assign bus.busy     = busy_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.rdata    = rdata_q;

endmodule
